decode_stage: RTL and testbench



---
 rtl/decode_pkg.sv | 81 ++++++++
 rtl/regfile_32x32.sv | 34 +++
 rtl/decode_stage.sv | 145 ++++++++++++++
 tb/tb_decode_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared opcode constants, instruction field positions and decode helpers
// for the decode stage and its register file.
package decode_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_ADDI = 6'd1;
    localparam logic [5:0] OP_LUI  = 6'd3;
    localparam logic [5:0] OP_ANDI = 6'd4;
    localparam logic [5:0] OP_ORI  = 6'd5;
    localparam logic [5:0] OP_XORI = 6'd6;
    localparam logic [5:0] OP_LW   = 6'd16;
    localparam logic [5:0] OP_LH   = 6'd18;
    localparam logic [5:0] OP_LB   = 6'd20;
    localparam logic [5:0] OP_SW   = 6'd24;
    localparam logic [5:0] OP_SH   = 6'd26;
    localparam logic [5:0] OP_SB   = 6'd28;
    localparam logic [5:0] OP_JAL  = 6'd41;

    localparam int unsigned OP_HI  = 31;
    localparam int unsigned OP_LO  = 26;
    localparam int unsigned RS_HI  = 25;
    localparam int unsigned RS_LO  = 21;
    localparam int unsigned RT_HI  = 20;
    localparam int unsigned RT_LO  = 16;
    localparam int unsigned RD_HI  = 15;
    localparam int unsigned RD_LO  = 11;
    localparam int unsigned AUX_HI = 10;
    localparam int unsigned AUX_LO = 0;
    localparam int unsigned IMM_HI = 15;
    localparam int unsigned IMM_LO = 0;
    localparam int unsigned TGT_HI = 25;
    localparam int unsigned TGT_LO = 0;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [10:0] aux;
        logic [15:0] imm;
        logic [25:0] tgt;
    } instr_fields_t;

    function automatic instr_fields_t split_instr(input logic [31:0] instr);
        instr_fields_t f;
        f.op  = instr[OP_HI:OP_LO];
        f.rs  = instr[RS_HI:RS_LO];
        f.rt  = instr[RT_HI:RT_LO];
        f.rd  = instr[RD_HI:RD_LO];
        f.aux = instr[AUX_HI:AUX_LO];
        f.imm = instr[IMM_HI:IMM_LO];
        f.tgt = instr[TGT_HI:TGT_LO];
        return f;
    endfunction

    function automatic logic [31:0] imm_ext(input instr_fields_t f);
        logic [31:0] r;
        r = '0;
        case (f.op)
            OP_ADDI, OP_LW, OP_LH, OP_LB, OP_SW, OP_SH, OP_SB: r = {{16{f.imm[15]}}, f.imm};
            OP_LUI, OP_ANDI, OP_ORI, OP_XORI:                  r = {16'h0000, f.imm};
            OP_JAL:                                            r = {6'b000000, f.tgt};
            default:                                           r = '0;
        endcase
        return r;
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LB);
    endfunction

    // Opcodes that read rt as a source operand (R-type and stores).
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_R) || (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/regfile_32x32.sv
// 32 x 32-bit register file: one synchronous write port, two asynchronous
// read ports, synchronous clear on reset; register 0 is hardwired to zero.
module regfile_32x32
    import decode_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [REG_AW-1:0] raddr_a_i,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [XLEN-1:0]   rdata_a_o,
    output logic [XLEN-1:0]   rdata_b_o
);

    logic [XLEN-1:0] mem_q [NREGS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
        rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field split, immediate extension, register read, load-use
// stall and a one-entry output register. Define DECODE_WB_BYPASS_EN to forward
// same-cycle writeback data into the captured operands.
module decode_stage
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,

    input  logic        wb_en,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] pc,
    output logic [5:0]  op,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [10:0] aux,
    output logic [31:0] os,
    output logic [31:0] ot,
    output logic [31:0] imm_dpl
);

    instr_fields_t f;
    logic [31:0]   rs_data;
    logic [31:0]   rt_data;
    logic [31:0]   os_src;
    logic [31:0]   ot_src;
    logic          hazard;
    logic          accept;

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [5:0]  op_q, op_d;
    logic [4:0]  rt_q, rt_d;
    logic [4:0]  rd_q, rd_d;
    logic [10:0] aux_q, aux_d;
    logic [31:0] os_q, os_d;
    logic [31:0] ot_q, ot_d;
    logic [31:0] imm_q, imm_d;

    assign f = split_instr(in_instr);

    regfile_32x32 u_regfile (
        .clk_i     (clk),
        .rst_i     (rst),
        .we_i      (wb_en),
        .waddr_i   (wb_reg),
        .wdata_i   (wb_data),
        .raddr_a_i (f.rs),
        .raddr_b_i (f.rt),
        .rdata_a_o (rs_data),
        .rdata_b_o (rt_data)
    );

`ifdef DECODE_WB_BYPASS_EN
    always_comb begin
        os_src = rs_data;
        ot_src = rt_data;
        if (wb_en && (wb_reg != '0) && (wb_reg == f.rs)) os_src = wb_data;
        if (wb_en && (wb_reg != '0) && (wb_reg == f.rt)) ot_src = wb_data;
    end
`else
    always_comb begin
        os_src = rs_data;
        ot_src = rt_data;
    end
`endif

    // Load in the output stage whose destination feeds the incoming instruction.
    always_comb begin
        hazard = valid_q && is_load(op_q) && (rt_q != '0) &&
                 ((rt_q == f.rs) || ((rt_q == f.rt) && reads_rt(f.op)));
        in_ready = (!valid_q || out_ready) && !hazard;
        accept   = in_valid && in_ready;
    end

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        op_d    = op_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        aux_d   = aux_q;
        os_d    = os_q;
        ot_d    = ot_q;
        imm_d   = imm_q;
        if (accept) begin
            valid_d = 1'b1;
            pc_d    = in_pc;
            op_d    = f.op;
            rt_d    = f.rt;
            rd_d    = f.rd;
            aux_d   = f.aux;
            os_d    = os_src;
            ot_d    = ot_src;
            imm_d   = imm_ext(f);
        end else if (out_ready) begin
            // Covers both the drained case and the load-use bubble.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            op_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            aux_q   <= '0;
            os_q    <= '0;
            ot_q    <= '0;
            imm_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            aux_q   <= aux_d;
            os_q    <= os_d;
            ot_q    <= ot_d;
            imm_q   <= imm_d;
        end
    end

    assign out_valid = valid_q;
    assign pc        = pc_q;
    assign op        = op_q;
    assign rt        = rt_q;
    assign rd        = rd_q;
    assign aux       = aux_q;
    assign os        = os_q;
    assign ot        = ot_q;
    assign imm_dpl   = imm_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: reset, operand read,
// immediate extension, load-use stall, downstream hold, bypass and mid-flight reset.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [10:0] aux;
    logic [31:0] os;
    logic [31:0] ot;
    logic [31:0] imm_dpl;

    int n_cmp = 0;
    int n_err = 0;

`ifdef DECODE_WB_BYPASS_EN
    localparam logic [31:0] BYP_EXP = 32'h0000_00AA;
`else
    localparam logic [31:0] BYP_EXP = 32'h0000_0000;
`endif

    decode_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .wb_en     (wb_en),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pc        (pc),
        .op        (op),
        .rt        (rt),
        .rd        (rd),
        .aux       (aux),
        .os        (os),
        .ot        (ot),
        .imm_dpl   (imm_dpl)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [5:0] o, input logic [4:0] s,
                                       input logic [4:0] t, input logic [15:0] imm);
        return {o, s, t, imm};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] p, input logic [31:0] i);
        in_valid = 1'b1;
        in_pc    = p;
        in_instr = i;
    endtask

    task automatic write_reg(input logic [4:0] r, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_reg  = r;
        wb_data = d;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        wb_en = 1'b0; wb_reg = '0; wb_data = '0; out_ready = 1'b1;
        step;
        step;
        rst = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_os", os, 32'd0);
        check("rst_imm", imm_dpl, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Operand read after writeback
        write_reg(5'd5, 32'h1234_5678);
        step;
        wb_en = 1'b0;
        drive(32'h100, mk(6'd0, 5'd5, 5'd0, 16'h1800));
        step;
        in_valid = 1'b0;
        check("rd_valid", 32'(out_valid), 32'd1);
        check("rd_os", os, 32'h1234_5678);
        check("rd_ot", ot, 32'd0);
        check("rd_rd", 32'(rd), 32'd3);
        check("rd_pc", pc, 32'h100);
        step;
        check("drain_valid", 32'(out_valid), 32'd0);

        // Immediate extension, back to back
        drive(32'h110, mk(6'd1, 5'd0, 5'd0, 16'hFFFC));
        step;
        check("imm_addi", imm_dpl, 32'hFFFF_FFFC);
        drive(32'h114, mk(6'd5, 5'd0, 5'd0, 16'hFFFC));
        step;
        check("imm_ori", imm_dpl, 32'h0000_FFFC);
        check("imm_ori_op", 32'(op), 32'd5);
        drive(32'h118, {6'd41, 26'h000_0100});
        step;
        check("imm_jal", imm_dpl, 32'h0000_0100);
        drive(32'h11C, mk(6'd2, 5'd0, 5'd0, 16'hFFFC));
        step;
        check("imm_other", imm_dpl, 32'd0);
        check("aux_other", 32'(aux), 32'h7FC);

        // Load-use on rs: one bubble
        drive(32'h300, mk(6'd16, 5'd0, 5'd7, 16'h0004));
        step;
        drive(32'h304, mk(6'd0, 5'd7, 5'd0, 16'h0000));
        #1;
        check("haz_rs_ready", 32'(in_ready), 32'd0);
        step;
        check("haz_bubble", 32'(out_valid), 32'd0);
        check("haz_ready_after", 32'(in_ready), 32'd1);
        step;
        in_valid = 1'b0;
        check("haz_issue_valid", 32'(out_valid), 32'd1);
        check("haz_issue_pc", pc, 32'h304);

        // Load followed by unrelated rs: no bubble
        drive(32'h310, mk(6'd16, 5'd0, 5'd7, 16'h0004));
        step;
        drive(32'h314, mk(6'd0, 5'd8, 5'd0, 16'h0000));
        #1;
        check("nohaz_ready", 32'(in_ready), 32'd1);
        step;
        check("nohaz_valid", 32'(out_valid), 32'd1);
        check("nohaz_pc", pc, 32'h314);

        // Load-use through rt of a store
        drive(32'h320, mk(6'd16, 5'd0, 5'd7, 16'h0004));
        step;
        drive(32'h324, mk(6'd24, 5'd0, 5'd7, 16'h0000));
        #1;
        check("haz_rt_ready", 32'(in_ready), 32'd0);
        step;
        check("haz_rt_bubble", 32'(out_valid), 32'd0);
        step;
        in_valid = 1'b0;
        check("haz_rt_pc", pc, 32'h324);
        step;
        check("haz_rt_drain", 32'(out_valid), 32'd0);

        // Downstream stall with writeback to a held source
        write_reg(5'd9, 32'h0000_0099);
        step;
        wb_en = 1'b0;
        drive(32'h200, mk(6'd0, 5'd9, 5'd5, 16'h1800));
        step;
        check("stall_os0", os, 32'h0000_0099);
        check("stall_ot0", ot, 32'h1234_5678);
        out_ready = 1'b0;
        drive(32'h204, mk(6'd0, 5'd1, 5'd1, 16'h0000));
        write_reg(5'd9, 32'h0000_1234);
        for (int i = 0; i < 3; i++) begin
            step;
            wb_en = 1'b0;
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_pc", pc, 32'h200);
            check("stall_os", os, 32'h0000_0099);
            check("stall_rd", 32'(rd), 32'd3);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step;
        check("stall_release", 32'(out_valid), 32'd0);
        drive(32'h208, mk(6'd0, 5'd9, 5'd0, 16'h0000));
        step;
        in_valid = 1'b0;
        check("stall_wb_landed", os, 32'h0000_1234);

        // Same-cycle writeback and read
        write_reg(5'd4, 32'h0000_00AA);
        drive(32'h400, mk(6'd0, 5'd4, 5'd4, 16'h0000));
        step;
        wb_en = 1'b0;
        check("byp_os", os, BYP_EXP);
        check("byp_ot", ot, BYP_EXP);
        step;
        check("byp_later_os", os, 32'h0000_00AA);
        write_reg(5'd0, 32'h0000_0055);
        drive(32'h404, mk(6'd0, 5'd0, 5'd0, 16'h0000));
        step;
        wb_en = 1'b0;
        check("r0_same_os", os, 32'd0);
        step;
        in_valid = 1'b0;
        check("r0_later_os", os, 32'd0);
        check("r0_later_ot", ot, 32'd0);

        // Reset with an instruction in flight
        drive(32'h500, mk(6'd0, 5'd5, 5'd0, 16'h1800));
        step;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        rst = 1'b1;
        drive(32'h504, mk(6'd1, 5'd5, 5'd6, 16'h0001));
        write_reg(5'd6, 32'h0000_0066);
        step;
        rst = 1'b0; wb_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_pc", pc, 32'd0);
        check("mid_rst_op", 32'(op), 32'd0);
        check("mid_rst_rt", 32'(rt), 32'd0);
        check("mid_rst_rd", 32'(rd), 32'd0);
        check("mid_rst_aux", 32'(aux), 32'd0);
        check("mid_rst_os", os, 32'd0);
        check("mid_rst_ot", ot, 32'd0);
        check("mid_rst_imm", imm_dpl, 32'd0);
        drive(32'h508, mk(6'd0, 5'd5, 5'd6, 16'h0000));
        step;
        in_valid = 1'b0;
        check("post_rst_r5", os, 32'd0);
        check("post_rst_r6", ot, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
